// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, frame constants and the default bit period.
package uart_defs;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam logic        UART_IDLE_LEVEL           = 1'b1;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// 16-bit bit-period counter: counts 0..CLKS_PER_BIT-1, flags the last cycle of each bit.
module baud_counter
  import uart_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);

  localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // The caller asserts restart on bit_end too, so the count wraps to 0 on every bit boundary.
  always_comb begin
    count_d = count_q + 16'd1;
    if (restart) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bit_end = (count_q == LAST_COUNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains an upstream FIFO onto an 8N1 UART line, LSB first. CLKS_PER_BIT must be within 2..65535.
module fifo_uart_tx
  import uart_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_pop,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       pop_q, pop_d;
  logic       done_q, done_d;
  logic       bit_end;
  logic       restart;

  // Counter is held at 0 outside the timed states so START always begins a full bit.
  assign restart = bit_end || (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_LOAD);

  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      ST_IDLE:  if (enable && !fifo_empty) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d = fifo_data;
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP:  if (bit_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered decodes of the current state: pins lag the state by one cycle,
  // uniformly, so they stay mutually aligned and free of input-to-output paths.
  // fifo_pop is a single-cycle strobe; the byte was captured in LOAD, so the FIFO may advance freely.
  always_comb begin
    tx_d   = UART_IDLE_LEVEL;
    busy_d = (state_q != ST_IDLE);
    pop_d  = (state_q == ST_LOAD);
    done_d = (state_q == ST_STOP) && bit_end;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
      pop_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      pop_q     <= pop_d;
      done_q    <= done_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign fifo_pop = pop_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx at CLKS_PER_BIT=4: upstream FIFO model, frame-level line monitor, directed tests.
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int         pop_cnt = 0;
  int         frames_done = 0;

  bit         in_frame = 1'b0;
  int         k = 0;
  logic [7:0] cur = '0;
  logic [9:0] frame_bits = '0;
  logic [9:0] last_bits = '0;
  int         gap_cnt = 0;
  int         gap_busy_low = 0;
  int         last_gap = -1;
  int         last_gap_busy_low = -1;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fifo_refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fq[0];
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
    fifo_refresh();
  endtask

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  // Line monitor: a frame is 10 bits of CPB cycles starting at the falling edge of tx.
  task automatic mon_step();
    int   b;
    logic exp_bit;
    if (reset) begin
      in_frame     = 1'b0;
      gap_cnt      = 0;
      gap_busy_low = 0;
      return;
    end
    if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame          = 1'b1;
        k                 = 0;
        frame_bits        = '0;
        last_gap          = gap_cnt;
        last_gap_busy_low = gap_busy_low;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start actual=frame expected=idle at %0t", $time);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
        end
      end else begin
        chk("idle_tx_done", tx_done, 0);
        gap_cnt++;
        if (busy === 1'b0) gap_busy_low++;
      end
    end
    if (in_frame) begin
      chk("frame_busy", busy, 1);
      chk("frame_tx_done", tx_done, (k == FRAME - 1));
      if ((k % CPB) == CPB / 2) begin
        b = k / CPB;
        if (b == 0) exp_bit = 1'b0;
        else if (b == 9) exp_bit = 1'b1;
        else exp_bit = cur[b-1];
        frame_bits[b] = tx;
        chk("bit_centre", tx, exp_bit);
      end
      if (k == FRAME - 1) begin
        in_frame     = 1'b0;
        frames_done++;
        last_bits    = frame_bits;
        gap_cnt      = 0;
        gap_busy_low = 0;
      end else begin
        k++;
      end
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      tick();
      n++;
    end
    chk("frame_timeout", (frames_done >= target), 1);
  endtask

  initial begin
    int p0;
    int f0;
    int hi;
    int n;
    reset  = 1'b1;
    enable = 1'b0;
    fifo_refresh();

    fork
      forever begin
        @(negedge clock);
        mon_step();
        if (fifo_pop === 1'b1) begin
          pop_cnt++;
          checks++;
          if (fq.size() == 0) begin
            errors++;
            $display("FAIL pop_when_empty actual=pop expected=no_pop at %0t", $time);
          end else begin
            fq.delete(0);
          end
          fifo_refresh();
        end
      end
    join_none

    repeat (3) @(negedge clock);
    #2;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pop", fifo_pop, 0);
    chk("rst_done", tx_done, 0);
    reset = 1'b0;

    // Empty FIFO with enable high: nothing may happen.
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("empty_pop", fifo_pop, 0);
      chk("empty_tx", tx, 1);
      chk("empty_busy", busy, 0);
    end

    // Single byte 0xA5.
    p0 = pop_cnt; f0 = frames_done;
    push(8'hA5);
    wait_frames(f0 + 1, 200);
    repeat (4) tick();
    chk("a5_bits", last_bits, 10'b1101001010);
    chk("a5_pops", pop_cnt - p0, 1);

    // Back-to-back 0x00, 0xFF.
    p0 = pop_cnt; f0 = frames_done;
    push(8'h00);
    push(8'hFF);
    wait_frames(f0 + 2, 300);
    repeat (4) tick();
    chk("b2b_gap", last_gap, 3);
    chk("b2b_busy_low", last_gap_busy_low, 1);
    chk("b2b_pops", pop_cnt - p0, 2);
    chk("ff_bits", last_bits, 10'b1111111110);

    // 0x3C held off by enable, then enable dropped mid-frame.
    p0 = pop_cnt; f0 = frames_done;
    enable = 1'b0;
    push(8'h3C);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("gated_tx", tx, 1);
      chk("gated_busy", busy, 0);
      chk("gated_pop", fifo_pop, 0);
    end
    enable = 1'b1;
    hi = 0;
    while (tx === 1'b1 && hi < 20) begin
      tick();
      if (tx === 1'b1) hi++;
    end
    chk("enable_to_start", hi, 3);
    repeat (12) tick();
    enable = 1'b0;
    wait_frames(f0 + 1, 200);
    repeat (4) tick();
    chk("3c_bits", last_bits, 10'b1001111000);
    chk("3c_pops", pop_cnt - p0, 1);

    // Reset during data bit 3 of 0x81.
    p0 = pop_cnt; f0 = frames_done;
    enable = 1'b1;
    push(8'h81);
    n = 0;
    while (!(in_frame && k == 17) && n < 200) begin
      tick();
      n++;
    end
    chk("reach_bit3", (in_frame && k == 17), 1);
    reset = 1'b1;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_pop", fifo_pop, 0);
    chk("midrst_done", tx_done, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("post_rst_tx", tx, 1);
      chk("post_rst_busy", busy, 0);
    end
    chk("post_rst_pops", pop_cnt - p0, 1);
    chk("post_rst_frames", frames_done - f0, 0);

    // 256 random bytes with random enable.
    p0 = pop_cnt; f0 = frames_done;
    for (int i = 0; i < 256; i++) push(8'($urandom_range(0, 255)));
    n = 0;
    while (frames_done < f0 + 256 && n < 30000) begin
      enable = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    chk("rand_timeout", (frames_done >= f0 + 256), 1);
    enable = 1'b1;
    repeat (4) tick();
    chk("rand_pops", pop_cnt - p0, 256);
    chk("rand_exp_left", exp_q.size(), 0);
    chk("rand_fifo_left", fq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning clock cycles per UART bit (100 MHz / 115200 baud); the legal range SHALL be 2..65535.
REQ-002 Port list SHALL be, in this order:
- clock  input  1  system clock; the block uses one clock, and all logic SHALL be on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  permits starting a new frame.
- fifo_data  input  8  head byte of the upstream FIFO.
- fifo_empty  input  1  upstream FIFO empty flag.
- fifo_pop  output  1  one-cycle pop strobe to the upstream FIFO.
- tx  output  1  serial line, idle high, 8N1, LSB first.
- busy  output  1  high while a frame is being fetched or sent.
- tx_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-003 The state machine SHALL have the states IDLE, FETCH, LOAD, START, DATA and STOP.
REQ-004 In IDLE, when enable=1 and fifo_empty=0, the next state SHALL be FETCH; otherwise the state SHALL remain IDLE.
REQ-005 FETCH SHALL last exactly 1 cycle, to cover the FIFO RAM registered-read latency; the next state SHALL be LOAD.
REQ-006 LOAD SHALL last exactly 1 cycle, SHALL latch fifo_data into an 8-bit shift register, and SHALL assert fifo_pop=1; the next state SHALL be START.
REQ-007 fifo_pop SHALL be 1 only in LOAD, so there SHALL be exactly one pop per frame and no pop while fifo_empty=1 was sampled in IDLE.
REQ-008 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-009 DATA SHALL drive tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit, for 8 bits counted by a 3-bit index; after bit 7 the next state SHALL be STOP.
REQ-010 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; in its last cycle tx_done SHALL be 1; the next state SHALL be IDLE.
REQ-011 tx SHALL be 1 in IDLE, FETCH and LOAD.
REQ-012 The frame length from the START entry to the IDLE re-entry SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-013 The baud counter SHALL be 16 bits, SHALL load 0 on entry to START, DATA-bit and STOP, and SHALL signal bit-end at count CLKS_PER_BIT-1.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 Back-to-back frames: when the FIFO is non-empty at the IDLE return, the next START SHALL begin 3 cycles after the STOP bit ends (IDLE, FETCH, LOAD).
REQ-016 enable deasserted mid-frame SHALL NOT abort the frame; it SHALL only gate the IDLE->FETCH transition.
REQ-017 fifo_empty rising during FETCH or LOAD SHALL be ignored; the latched byte SHALL be sent.
REQ-018 fifo_data changes after LOAD SHALL NOT affect the frame in flight.

Reset
REQ-019 Reset SHALL act asynchronously: state=IDLE, tx=1, busy=0, fifo_pop=0, tx_done=0, shift register=0, bit index=0, baud counter=0.
REQ-020 Reset asserted mid-frame SHALL immediately force tx=1 and SHALL discard the partial byte; that byte has already been popped and SHALL NOT be retransmitted.
REQ-021 After reset deassertion, the first frame SHALL start no earlier than the first clock edge with reset low.

Structure
REQ-022 A shared include/package (uart_defs) SHALL hold the state encodings, UART_DATA_BITS=8, UART_IDLE_LEVEL=1 and the default CLKS_PER_BIT.
REQ-023 One sub-module, baud_counter, SHALL be used: parameter CLKS_PER_BIT, inputs clock, reset and restart, output bit_end.
REQ-024 All outputs SHALL be registered; there SHALL be no combinational path from any input to tx.

Verification (CLKS_PER_BIT=4)
REQ-025 FIFO holds 0xA5, enable=1 -> fifo_pop pulses once; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done pulses once at cycle 40 after START.
REQ-026 FIFO holds 0x00, then 0xFF -> two frames separated by exactly 3 idle-high cycles; 2 pops total; busy drops for 1 cycle between frames.
REQ-027 fifo_empty=1, enable=1 for 100 cycles -> fifo_pop never 1, tx=1, busy=0.
REQ-028 0x3C queued, enable=0 for 50 cycles, then enable=1 -> no activity during the enable=0 cycles; a frame starts 3 cycles after enable rises; enable dropped during DATA -> frame completes.
REQ-029 reset pulsed during DATA bit 3 of 0x81 -> tx=1, busy=0 in the same cycle as reset; after release with the FIFO empty, the line stays idle with no retransmit.
REQ-030 The checker SHALL sample tx at bit centres and SHALL compare against a reference model for 256 random bytes pushed through fifo_ram with random enable -> zero mismatches and pop count=256.
